// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, fetches over a req/ack port and hands instructions to decode
module fetch_controller #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  PC_INC      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    Next_PC,
  output logic                   if_valid
);
  typedef enum logic {FETCH, DRAIN} state_t;
  state_t                 state, state_nx;
  logic [PC_WIDTH-1:0]    pc, pc_nx, pending_target, pending_nx, npc_nx, pc_inc;
  logic [INSTR_WIDTH-1:0] instr_nx;
  logic                   busy, busy_nx, valid_nx;
  // busy marks a FETCH request already presented but not yet acked, so it must be held
  assign imem_req  = rst_n & ((state == DRAIN) | busy | !if_valid | !stall);
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_WIDTH'(PC_INC);
  // next-state: redirects win over accept/stall; in-flight redirects wait in DRAIN for the ack
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pending_nx = pending_target;
    busy_nx    = busy;
    instr_nx   = instruction;
    npc_nx     = Next_PC;
    valid_nx   = if_valid & stall;
    if (state == DRAIN) begin
      valid_nx   = 1'b0;
      pending_nx = branch_taken ? branch_target : pending_target;
      if (imem_ack) begin
        pc_nx    = branch_taken ? branch_target : pending_target;
        state_nx = FETCH;
      end
    end else if (branch_taken) begin
      valid_nx = 1'b0;
      busy_nx  = 1'b0;
      if (imem_req && !imem_ack) begin
        pending_nx = branch_target;
        state_nx   = DRAIN;
      end else begin
        pc_nx = branch_target;
      end
    end else if (imem_req && imem_ack) begin
      instr_nx = imem_rdata;
      npc_nx   = pc_inc;
      pc_nx    = pc_inc;
      valid_nx = 1'b1;
      busy_nx  = 1'b0;
    end else begin
      busy_nx = imem_req;
    end
  end
  // state and output registers; async reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      pending_target <= '0;
      busy           <= 1'b0;
      instruction    <= '0;
      Next_PC        <= RESET_PC;
      if_valid       <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      pending_target <= pending_nx;
      busy           <= busy_nx;
      instruction    <= instr_nx;
      Next_PC        <= npc_nx;
      if_valid       <= valid_nx;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random checks of fetch_controller against a transaction model
module tb_fetch_controller;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, stall = 1'b0, branch_taken = 1'b0, if_valid;
  logic [15:0] imem_addr, imem_rdata = '0, branch_target = '0, instruction, Next_PC;
  int          total = 0, passed = 0;

  logic        m_v, m_inflight, m_discard;
  logic [15:0] m_pc, m_instr, m_npc, m_iaddr, m_redir;

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .instruction(instruction), .Next_PC(Next_PC), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask

  task automatic m_reset();
    m_v = 0; m_inflight = 0; m_discard = 0;
    m_pc = 16'h0000; m_instr = '0; m_npc = 16'h0000; m_iaddr = '0; m_redir = '0;
  endtask

  // one cycle: drive at negedge, compare settled outputs with the model, advance the model
  task automatic step(input logic st, input logic br, input logic [15:0] tgt, input logic ak);
    logic        e_req;
    logic [15:0] e_addr;
    stall = st; branch_taken = br; branch_target = tgt; imem_ack = ak;
    e_req  = m_inflight | !m_v | !st;
    e_addr = m_inflight ? m_iaddr : m_pc;
    imem_rdata = e_addr ^ 16'hA5A5;
    #1;
    chk("imem_req", {15'b0, imem_req}, {15'b0, e_req});
    chk("imem_addr", imem_addr, e_addr);
    chk("if_valid", {15'b0, if_valid}, {15'b0, m_v});
    if (m_v) begin
      chk("instruction", instruction, m_instr);
      chk("Next_PC", Next_PC, m_npc);
    end
    if (m_inflight && m_discard) begin
      if (br) m_redir = tgt;
      if (ak) begin
        m_pc = br ? tgt : m_redir;
        m_inflight = 0; m_discard = 0;
      end
    end else if (br) begin
      m_v = 0;
      if (e_req && !ak) begin
        m_inflight = 1; m_discard = 1; m_iaddr = e_addr; m_redir = tgt;
      end else begin
        m_pc = tgt; m_inflight = 0;
      end
    end else if (e_req && ak) begin
      m_instr = e_addr ^ 16'hA5A5;
      m_pc = m_pc + 16'd1;
      m_npc = m_pc;
      m_v = 1; m_inflight = 0;
    end else begin
      if (!st) m_v = 0;
      if (e_req) begin m_inflight = 1; m_iaddr = e_addr; end
    end
    @(negedge clk);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst imem_req", {15'b0, imem_req}, 16'd0);
    chk("rst imem_addr", imem_addr, 16'h0000);
    chk("rst if_valid", {15'b0, if_valid}, 16'd0);
    chk("rst Next_PC", Next_PC, 16'h0000);
    chk("rst instruction", instruction, 16'h0000);
    rst_n = 1'b1;
    // zero-wait stream
    step(0, 0, 0, 1);
    chk("zw0 instr", instruction, 16'hA5A5); chk("zw0 npc", Next_PC, 16'h0001);
    step(0, 0, 0, 1);
    chk("zw1 instr", instruction, 16'hA5A4); chk("zw1 npc", Next_PC, 16'h0002);
    step(0, 0, 0, 1);
    chk("zw2 instr", instruction, 16'hA5A7); chk("zw2 npc", Next_PC, 16'h0003);
    chk("zw2 addr", imem_addr, 16'h0003);
    step(0, 0, 0, 1);
    // slow ack on 0x0004
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("wait req", {15'b0, imem_req}, 16'd1); chk("wait addr", imem_addr, 16'h0004);
    end
    step(0, 0, 0, 1);
    chk("slow npc", Next_PC, 16'h0005); chk("slow valid", {15'b0, if_valid}, 16'd1);
    // decode stall holds the entry
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1);
      chk("stall req", {15'b0, imem_req}, 16'd0);
      chk("stall npc", Next_PC, 16'h0005); chk("stall instr", instruction, 16'hA5A1);
    end
    step(0, 0, 0, 0);
    // redirects while 0x0005 is outstanding
    step(0, 1, 16'h0100, 0);
    step(0, 0, 0, 0);
    step(0, 1, 16'h0200, 0);
    step(0, 0, 0, 0);
    chk("drain addr", imem_addr, 16'h0005); chk("drain req", {15'b0, imem_req}, 16'd1);
    chk("drain valid", {15'b0, if_valid}, 16'd0);
    step(0, 0, 0, 1);
    chk("redir addr", imem_addr, 16'h0200); chk("redir valid", {15'b0, if_valid}, 16'd0);
    step(0, 0, 0, 1);
    chk("redir npc", Next_PC, 16'h0201);
    // branch while stalled with nothing outstanding
    step(1, 1, 16'h0040, 0);
    chk("br40 valid", {15'b0, if_valid}, 16'd0); chk("br40 addr", imem_addr, 16'h0040);
    step(0, 0, 0, 1);
    chk("br40 npc", Next_PC, 16'h0041);
    // PC wrap
    step(0, 1, 16'hFFFF, 1);
    step(0, 0, 0, 1);
    chk("wrap npc", Next_PC, 16'h0000); chk("wrap addr", imem_addr, 16'h0000);
    chk("wrap instr", instruction, 16'h5A5A);
    // async reset in DRAIN
    step(0, 0, 0, 0);
    step(0, 1, 16'h0123, 0);
    chk("pre-rst drain req", {15'b0, imem_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async req", {15'b0, imem_req}, 16'd0);
    chk("async valid", {15'b0, if_valid}, 16'd0);
    chk("async npc", Next_PC, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] t;
      t = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t, $urandom_range(0, 1) == 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
